// File: rtl/ccip_arb_pkg.sv
// Shared types and width helpers for the CCI c0 read-request arbiter.
package ccip_arb_pkg;

  // Width of the client id carried in the top bits of host mdata.
  function automatic int unsigned client_bits(input int unsigned n_clients);
    return $clog2(n_clients);
  endfunction

  // Width of a counter that must hold the values 0..max_out inclusive.
  function automatic int unsigned credit_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam int unsigned DefNClients       = 4;
  localparam int unsigned DefMdataWidth     = 16;
  localparam int unsigned DefMaxOutstanding = 128;
  localparam int unsigned DefClientBits     = $clog2(DefNClients);
  localparam int unsigned DefCreditWidth    = $clog2(DefMaxOutstanding + 1);

  // Default-configuration views of the tag fields and the credit counter.
  typedef logic [DefClientBits-1:0]               t_client_id;
  typedef logic [DefMdataWidth-DefClientBits-1:0] t_cl_mdata;
  typedef logic [DefCreditWidth-1:0]              t_credit;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i wins.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic            enable_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  // Scan from the pointer; N is a power of two so the index add wraps naturally.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = rr_ptr_i + IdxW'(i);
      if (enable_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/ccip_read_req_arbiter.sv
// Shares the CCI c0 read-request channel among N_CLIENTS requesters, tags mdata with the
// client id, demuxes responses back and enforces almfull plus an outstanding-read limit.
module ccip_read_req_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS       = 4,
  parameter int unsigned ADDR_WIDTH      = 42,
  parameter int unsigned MDATA_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 128,
  localparam int unsigned CLIENT_BITS    = client_bits(N_CLIENTS),
  localparam int unsigned ClMdataW       = MDATA_WIDTH - CLIENT_BITS,
  localparam int unsigned CntW           = credit_width(MAX_OUTSTANDING)
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [N_CLIENTS-1:0]           cl_req_valid,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  input  logic [N_CLIENTS*ClMdataW-1:0]  cl_req_mdata,
  output logic [N_CLIENTS-1:0]           cl_req_grant,
  output logic                           c0_tx_valid,
  output logic [ADDR_WIDTH-1:0]          c0_tx_addr,
  output logic [MDATA_WIDTH-1:0]         c0_tx_mdata,
  input  logic                           c0_tx_almfull,
  input  logic                           c0_rx_valid,
  input  logic [MDATA_WIDTH-1:0]         c0_rx_mdata,
  input  logic [DATA_WIDTH-1:0]          c0_rx_data,
  output logic [N_CLIENTS-1:0]           cl_rsp_valid,
  output logic [ClMdataW-1:0]            cl_rsp_mdata,
  output logic [DATA_WIDTH-1:0]          cl_rsp_data,
  output logic [CntW-1:0]                outstanding,
  output logic                           err_underflow
);

  logic                   can_issue;
  logic                   gnt_any;
  logic [CLIENT_BITS-1:0] grant_idx;
  logic [CLIENT_BITS-1:0] rx_id;

  logic [CLIENT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
  logic [MDATA_WIDTH-1:0] tx_mdata_q, tx_mdata_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [N_CLIENTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [ClMdataW-1:0]    rsp_mdata_q, rsp_mdata_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  // Credit check uses the registered count so it can never overshoot the limit.
  assign can_issue = !c0_tx_almfull && (cnt_q < CntW'(MAX_OUTSTANDING));
  assign gnt_any   = |cl_req_grant;
  assign rx_id     = c0_rx_mdata[MDATA_WIDTH-1 -: CLIENT_BITS];

  rr_arbiter #(
    .N(N_CLIENTS)
  ) u_rr_arbiter (
    .req_i      (cl_req_valid),
    .enable_i   (can_issue),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (cl_req_grant),
    .grant_idx_o(grant_idx)
  );

  // Issue path, round-robin pointer and outstanding-read accounting.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tx_valid_d = gnt_any;
    tx_addr_d  = tx_addr_q;
    tx_mdata_d = tx_mdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (gnt_any) begin
      rr_ptr_d   = grant_idx + CLIENT_BITS'(1);
      tx_addr_d  = cl_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      tx_mdata_d = {grant_idx, cl_req_mdata[grant_idx*ClMdataW +: ClMdataW]};
    end
    if (c0_rx_valid && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
    case ({gnt_any, c0_rx_valid})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response demux: strobe the client named in the top mdata bits, strip the id.
  always_comb begin
    rsp_valid_d = '0;
    rsp_mdata_d = rsp_mdata_q;
    rsp_data_d  = rsp_data_q;
    if (c0_rx_valid) begin
      rsp_valid_d[rx_id] = 1'b1;
      rsp_mdata_d        = c0_rx_mdata[ClMdataW-1:0];
      rsp_data_d         = c0_rx_data;
    end
  end

  // State registers; reset clears everything including in-flight accounting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_mdata_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tx_valid_q  <= tx_valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_mdata_q  <= tx_mdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mdata_q <= rsp_mdata_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign c0_tx_valid   = tx_valid_q;
  assign c0_tx_addr    = tx_addr_q;
  assign c0_tx_mdata   = tx_mdata_q;
  assign cl_rsp_valid  = rsp_valid_q;
  assign cl_rsp_mdata  = rsp_mdata_q;
  assign cl_rsp_data   = rsp_data_q;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

endmodule
